// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch and data
// (MEM) pipeline stages. MEM requests win over fetches; each bus transaction
// is aborted with a one-cycle bus_err pulse if bus_ack does not arrive within
// ACK_TIMEOUT busy cycles.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   stall[5:0]          pipeline stall vector (bit 1 IF/ID held, bit 4 MEM/WB held)
//   if_ce, if_addr      fetch request / address
//   if_rdata            fetched instruction (registered)
//   stallreq_if         fetch not yet complete
//   mem_ce, mem_we, mem_sel, mem_addr, mem_wdata   data access request
//   mem_rdata           load data (registered)
//   stallreq_mem        data access not yet complete
//   bus_req, bus_we, bus_sel, bus_addr, bus_wdata  shared memory port (registered)
//   bus_ack, bus_rdata  memory response
//   bus_err             one-cycle pulse on timeout abort
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              if_ce,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stallreq_if,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              mem_done_q, mem_done_d;
  logic              if_done_q, if_done_d;
  logic              bus_req_d, bus_we_d, bus_err_d;
  logic [3:0]        bus_sel_d;
  logic [DATA_W-1:0] bus_addr_d, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;

  // Only the IF/ID and MEM/WB hold bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  // Stall requests follow the registered done flags.
  assign stallreq_mem = mem_ce & ~mem_done_q;
  assign stallreq_if  = if_ce & ~if_done_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CNT_W'(1);
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_sel_d   = bus_sel;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata;
    mem_rdata_d = mem_rdata;
    // A done flag drops once its pipeline register advances; a completion
    // below on the same edge takes precedence.
    mem_done_d  = stall[4] ? mem_done_q : 1'b0;
    if_done_d   = stall[1] ? if_done_q  : 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_ce && !mem_done_q) begin
          state_d     = MEM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_sel_d   = mem_sel;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
        end else if (if_ce && !if_done_q) begin
          state_d     = IF_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
        end
      end

      MEM_BUSY: begin
        if (bus_ack) begin
          if (!bus_we) mem_rdata_d = bus_rdata;
          mem_done_d = 1'b1;
          bus_req_d  = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (cnt_inc == CNT_LAST) begin
          mem_rdata_d = '0;
          mem_done_d  = 1'b1;
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      IF_BUSY: begin
        if (bus_ack) begin
          if_rdata_d = bus_rdata;
          if_done_d  = 1'b1;
          bus_req_d  = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (cnt_inc == CNT_LAST) begin
          if_rdata_d = '0;
          if_done_d  = 1'b1;
          bus_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_done_q <= 1'b0;
      if_done_q  <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_done_q <= mem_done_d;
      if_done_q  <= if_done_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_sel    <= bus_sel_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      bus_err    <= bus_err_d;
      if_rdata   <= if_rdata_d;
      mem_rdata  <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized fetch/load/
// store traffic. Expected bus transactions and completions are queued when
// stimulus is issued; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk, rst;
  logic [5:0]    stall;
  logic          if_ce;
  logic [DW-1:0] if_addr, if_rdata;
  logic          stallreq_if;
  logic          mem_ce, mem_we;
  logic [3:0]    mem_sel;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          stallreq_mem;
  logic          bus_req, bus_we;
  logic [3:0]    bus_sel;
  logic [DW-1:0] bus_addr, bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          bus_err;

  logic          resp_ack, main_ack;
  logic [DW-1:0] resp_rdata, main_rdata;
  assign bus_ack   = resp_ack | main_ack;
  assign bus_rdata = main_ack ? main_rdata : resp_rdata;

  mem_arbiter #(.DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata), .stallreq_if(stallreq_if),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic          we;
    logic [3:0]    sel;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;     // required idle cycles before this request, -1 = any
  } bus_t;

  typedef struct {
    bit            is_if;
    logic [DW-1:0] rdata;
    bit            err;
  } rsp_t;

  typedef struct {
    int            d;       // busy cycle carrying bus_ack, 0 = never
    logic [DW-1:0] rdata;
  } ack_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  ack_t ack_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference view of the two read-data registers.
  logic [DW-1:0] exp_if, exp_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Memory responder: acks each transaction in the busy cycle taken from ack_q.
  initial begin
    ack_t a;
    resp_ack   = 1'b0;
    resp_rdata = '0;
    forever begin
      @(negedge clk iff (bus_req === 1'b1 && rst === 1'b1));
      if (ack_q.size() > 0) begin
        a = ack_q.pop_front();
        if (a.d > 0) begin
          repeat (a.d - 1) @(negedge clk);
          resp_rdata = a.rdata;
          resp_ack   = 1'b1;
          @(negedge clk);
          resp_ack   = 1'b0;
        end
      end
      while (bus_req === 1'b1) @(negedge clk);
    end
  end

  // Monitor: compares bus requests and completions against the scoreboard.
  logic prev_req;
  int   gap;
  bus_t cur, mb;
  rsp_t mr;
  bit   have_cur;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_req = 1'b0;
      gap      = 0;
      have_cur = 1'b0;
    end else begin
      if (bus_req && !prev_req) begin
        if (exp_bus.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected bus_req: addr 0x%08h, no request pending", bus_addr);
          have_cur = 1'b0;
        end else begin
          mb = exp_bus.pop_front();
          chk("bus_we", 32'(bus_we), 32'(mb.we));
          chk("bus_sel", 32'(bus_sel), 32'(mb.sel));
          chk("bus_addr", bus_addr, mb.addr);
          chk("bus_wdata", bus_wdata, mb.wdata);
          if (mb.gap >= 0) chk("idle gap", 32'(gap), 32'(mb.gap));
          cur      = mb;
          have_cur = 1'b1;
        end
        chk("bus_err start", 32'(bus_err), 32'(0));
      end else if (bus_req) begin
        if (have_cur) begin
          chk("bus_we hold", 32'(bus_we), 32'(cur.we));
          chk("bus_sel hold", 32'(bus_sel), 32'(cur.sel));
          chk("bus_addr hold", bus_addr, cur.addr);
          chk("bus_wdata hold", bus_wdata, cur.wdata);
        end
        chk("bus_err busy", 32'(bus_err), 32'(0));
      end else if (prev_req) begin
        gap = 1;
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected completion: no response pending");
        end else begin
          mr = exp_rsp.pop_front();
          if (mr.is_if) begin
            chk("if_rdata", if_rdata, mr.rdata);
            chk("stallreq_if done", 32'(stallreq_if), 32'(0));
          end else begin
            chk("mem_rdata", mem_rdata, mr.rdata);
            chk("stallreq_mem done", 32'(stallreq_mem), 32'(0));
          end
          chk("bus_err end", 32'(bus_err), 32'(mr.err));
        end
      end else begin
        gap++;
        chk("bus_err idle", 32'(bus_err), 32'(0));
      end
      prev_req = bus_req;
    end
  end

  // Issue one fetch and/or one data access, queue expectations, and act as
  // the pipeline: hold the requester's stall bit for *hold cycles after
  // completion, then drop the request.
  task automatic run_txn(
    input bit do_if, input logic [31:0] ia, input int idl, input logic [31:0] idata, input int ihold,
    input bit do_mem, input bit we, input logic [3:0] sel, input logic [31:0] ma,
    input logic [31:0] wd, input int mdl, input logic [31:0] mdata, input int mhold);
    bit   if_pend, mem_pend, err;
    int   ih, mh, budget;
    bus_t b;
    rsp_t r;
    ack_t a;
    if (do_mem) begin
      b = '{we, sel, ma, wd, -1};
      exp_bus.push_back(b);
      a = '{mdl, mdata};
      ack_q.push_back(a);
      err = (mdl == 0 || mdl > TO);
      if (err) exp_mem = '0;
      else if (!we) exp_mem = mdata;
      r = '{1'b0, exp_mem, err};
      exp_rsp.push_back(r);
    end
    if (do_if) begin
      b = '{1'b0, 4'hF, ia, 32'h0, (do_mem ? 1 : -1)};
      exp_bus.push_back(b);
      a = '{idl, idata};
      ack_q.push_back(a);
      err = (idl == 0 || idl > TO);
      exp_if = err ? 32'h0 : idata;
      r = '{1'b1, exp_if, err};
      exp_rsp.push_back(r);
    end
    @(negedge clk);
    if (do_mem) begin
      mem_ce = 1'b1; mem_we = we; mem_sel = sel; mem_addr = ma; mem_wdata = wd;
      if (mhold > 0) stall[4] = 1'b1;
    end
    if (do_if) begin
      if_ce = 1'b1; if_addr = ia;
      if (ihold > 0) stall[1] = 1'b1;
    end
    #1;
    if (do_mem) chk("stallreq_mem raised", 32'(stallreq_mem), 32'(1));
    if (do_if)  chk("stallreq_if raised", 32'(stallreq_if), 32'(1));
    if_pend = do_if; mem_pend = do_mem; ih = ihold; mh = mhold; budget = 0;
    while ((if_pend || mem_pend) && budget < 60) begin
      @(negedge clk);
      budget++;
      if (mem_pend && !stallreq_mem) begin
        if (mh > 0) begin
          stall[4] = 1'b1;
          mh--;
          chk("mem_rdata held", mem_rdata, exp_mem);
        end else begin
          stall[4] = 1'b0; mem_ce = 1'b0; mem_pend = 1'b0;
        end
      end
      if (if_pend && !stallreq_if) begin
        if (ih > 0) begin
          stall[1] = 1'b1;
          ih--;
          chk("if_rdata held", if_rdata, exp_if);
        end else begin
          stall[1] = 1'b0; if_ce = 1'b0; if_pend = 1'b0;
        end
      end
    end
    if (if_pend || mem_pend) begin
      n_checks++;
      n_errors++;
      $display("FAIL txn timeout: request still pending after %0d cycles", budget);
      if_ce = 1'b0; mem_ce = 1'b0; stall = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    bus_t b;
    ack_t a;
    int   kind;
    rst = 1'b1; stall = '0; if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    main_ack = 1'b0; main_rdata = '0;
    exp_if = '0; exp_mem = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset bus_req", 32'(bus_req), 32'(0));
    chk("reset bus_we", 32'(bus_we), 32'(0));
    chk("reset bus_sel", 32'(bus_sel), 32'(0));
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_wdata", bus_wdata, 32'h0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset mem_rdata", mem_rdata, 32'h0);
    chk("reset bus_err", 32'(bus_err), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fetch with ack in the third busy cycle.
    run_txn(1, 32'h100, 3, 32'h2402_0005, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    chk("fetch result", if_rdata, 32'h2402_0005);
    // Contention: load wins, fetch follows after one idle cycle.
    run_txn(1, 32'h104, 2, 32'h0000_1111, 0, 1, 0, 4'hF, 32'h200, 32'h0, 1, 32'h5555_AAAA, 0);
    // Store leaves mem_rdata untouched.
    run_txn(0, 0, 0, 0, 0, 1, 1, 4'b0011, 32'h300, 32'h0000_ABCD, 2, 32'hFFFF_FFFF, 0);
    chk("store keeps mem_rdata", mem_rdata, 32'h5555_AAAA);
    // Load completing under a four-cycle MEM/WB hold.
    run_txn(0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h304, 32'h0, 2, 32'h1234_5678, 4);
    // Timeout with no ack, then ack exactly on the timeout cycle.
    run_txn(0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h600, 32'h0, 0, 32'h0, 0);
    chk("timeout mem_rdata", mem_rdata, 32'h0);
    run_txn(0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h604, 32'h0, TO, 32'hCAFE_F00D, 0);
    run_txn(1, 32'h700, 0, 32'h0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0);

    // Ack while idle is ignored.
    @(negedge clk);
    main_rdata = 32'hA5A5_5A5A; main_ack = 1'b1;
    repeat (2) @(negedge clk);
    main_ack = 1'b0;
    @(negedge clk);
    chk("idle ack if_rdata", if_rdata, exp_if);
    chk("idle ack mem_rdata", mem_rdata, exp_mem);
    chk("idle ack bus_req", 32'(bus_req), 32'(0));

    // Reset while a fetch is in flight.
    b = '{1'b0, 4'hF, 32'h500, 32'h0, -1};
    exp_bus.push_back(b);
    a = '{0, 32'h0};
    ack_q.push_back(a);
    @(negedge clk);
    if_ce = 1'b1; if_addr = 32'h500;
    for (int i = 0; i < 10 && bus_req !== 1'b1; i++) @(negedge clk);
    chk("bus_req before reset", 32'(bus_req), 32'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("bus_req async reset", 32'(bus_req), 32'(0));
    chk("bus_addr async reset", bus_addr, 32'h0);
    @(negedge clk);
    if_ce = 1'b0; exp_if = '0; exp_mem = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    main_rdata = 32'hDEAD_BEEF; main_ack = 1'b1;
    @(negedge clk);
    main_ack = 1'b0;
    @(negedge clk);
    chk("late ack if_rdata", if_rdata, 32'h0);
    chk("late ack mem_rdata", mem_rdata, 32'h0);
    chk("late ack bus_req", 32'(bus_req), 32'(0));

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 2));
      run_txn(kind != 1, $urandom() & 32'hFFFF_FFFC, int'($urandom_range(0, TO)), $urandom(),
              int'($urandom_range(0, 3)),
              kind != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
              $urandom() & 32'hFFFF_FFFC, $urandom(), int'($urandom_range(0, TO)), $urandom(),
              int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("bus queue drained", 32'(exp_bus.size()), 32'(0));
    chk("response queue drained", 32'(exp_rsp.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of every address and data port.
REQ-002 Parameter: ACK_TIMEOUT, 255, maximum cycles a bus transaction waits for bus_ack before it is aborted.
REQ-003 Port: clk  in  1  single clock; all state changes on posedge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: stall  in  6  pipeline stall vector; bit 1 = IF/ID register held, bit 4 = MEM/WB register held.
REQ-006 Port: if_ce  in  1  fetch request, held until the fetch is consumed.
REQ-007 Port: if_addr  in  DATA_W  fetch address.
REQ-008 Port: if_rdata  out  DATA_W  fetched instruction.
REQ-009 Port: stallreq_if  out  1  fetch-not-ready stall request.
REQ-010 Port: mem_ce, mem_we  in  1 each  data access request; write when mem_we=1.
REQ-011 Port: mem_sel  in  4  byte enables; mem_addr, mem_wdata  in  DATA_W.
REQ-012 Port: mem_rdata  out  DATA_W  load data; stallreq_mem  out  1  data-not-ready stall request.
REQ-013 Port: bus_req, bus_we  out  1; bus_sel  out  4; bus_addr, bus_wdata  out  DATA_W  shared memory port.
REQ-014 Port: bus_ack  in  1; bus_rdata  in  DATA_W  memory response.
REQ-015 Port: bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-016 FSM states: IDLE, MEM_BUSY, IF_BUSY; all bus_* outputs are registered.
REQ-017 IDLE with mem_ce=1 and mem_done=0: go to MEM_BUSY, latch mem_addr/mem_we/mem_sel/mem_wdata onto bus_*, set bus_req=1.
REQ-018 IDLE with if_ce=1, if_done=0, and no eligible MEM request: go to IF_BUSY, bus_addr=if_addr, bus_we=0, bus_sel=4'hF, bus_wdata=0, bus_req=1.
REQ-019 Simultaneous eligible MEM and IF requests in IDLE: MEM is always served first; IF waits with stallreq_if=1.
REQ-020 In a BUSY state bus_* hold stable until bus_ack=1; a cycle counter increments each BUSY cycle.
REQ-021 bus_ack=1 in MEM_BUSY: mem_rdata<=bus_rdata for reads (unchanged for writes), mem_done<=1, bus_req<=0, counter cleared, go to IDLE.
REQ-022 bus_ack=1 in IF_BUSY: if_rdata<=bus_rdata, if_done<=1, bus_req<=0, counter cleared, go to IDLE.
REQ-023 bus_req is low for at least one cycle between consecutive transactions.
REQ-024 Timeout: counter reaches ACK_TIMEOUT with bus_ack=0 -> abort; rdata of the owner <=0, done<=1, bus_req<=0, bus_err=1 for one cycle, go to IDLE.
REQ-025 bus_ack=1 on the timeout cycle is a normal completion: ack wins, no bus_err.
REQ-026 bus_ack while IDLE is ignored; no state or data change.
REQ-027 stallreq_mem = mem_ce & ~mem_done; stallreq_if = if_ce & ~if_done; both combinational from registered state.
REQ-028 mem_done clears on a posedge where stall[4]=0; if_done clears on a posedge where stall[1]=0; otherwise held, with rdata held.
REQ-029 A done flag that is set blocks a new transaction for that requester until it clears.
REQ-030 Counter width is ceil(log2(ACK_TIMEOUT+1)); no wrap.

Reset
REQ-031 rst=0 asynchronously forces IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, if_rdata=0, mem_rdata=0, both done flags=0, counter=0, bus_err=0.
REQ-032 Reset during a BUSY state abandons the transaction; bus_req falls without waiting for the clock; a late bus_ack after release is ignored.

Verification
REQ-033 IF read: if_ce=1, if_addr=0x100, bus_ack 3 cycles after bus_req with bus_rdata=0x24020005 -> if_rdata=0x24020005, stallreq_if falls the cycle after ack.
REQ-034 Contention: if_ce=1 and mem_ce=1 (read 0x200) in the same cycle -> bus_addr=0x200 first; after ack, one idle cycle; then bus_addr=IF address.
REQ-035 Store: mem_we=1, mem_sel=4'b0011, mem_addr=0x300, mem_wdata=0xABCD -> bus_we=1 and bus_sel=4'b0011 held until ack; mem_rdata unchanged.
REQ-036 Hold: ack for a load completes while stall[4]=1 for 4 cycles -> mem_rdata stable, no new bus_req for MEM; mem_done clears once stall[4]=0.
REQ-037 Timeout: ACK_TIMEOUT=4, no ack -> bus_err pulse on cycle 4, mem_rdata=0, stallreq_mem falls; repeat with ack on cycle 4 -> no bus_err.
REQ-038 Reset mid-transaction: rst=0 during IF_BUSY -> bus_req=0 before the next edge; ack after release produces no if_rdata change.
